// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: valid/ready request, wait states, byte-lane access, valid/ready response
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned halfword/word returns rsp_err instead of force-aligning)
module dmem_responder #(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         AW        = DMEM_ADDR_WIDTH + 2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        access;

    logic          lat_write, lat_unsigned;
    logic [AW-1:0] lat_addr;
    logic [1:0]    lat_size;
    logic [31:0]   lat_wdata;

    logic          src_write, src_unsigned;
    logic [AW-1:0] src_addr;
    logic [1:0]    src_size;
    logic [31:0]   src_wdata;

    logic [1:0]  lane;
    logic        misalign;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd_word;
    logic [31:0] ld_data;
    logic        do_write;

    logic [31:0] mem [DMEM_DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:AW]};

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // With zero wait states the access happens on the accept edge, so read the live request.
    assign src_write    = (state == IDLE) ? req_write    : lat_write;
    assign src_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
    assign src_addr     = (state == IDLE) ? req_addr[AW-1:0] : lat_addr;
    assign src_size     = (state == IDLE) ? req_size     : lat_size;
    assign src_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_LOAD == 4'd0) begin
                        access     = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = WAIT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lane     = src_addr[1:0];
        misalign = 1'b0;
        if (src_size == 2'b01) begin
`ifdef DMEM_MISALIGN_CHECK_EN
            misalign = lane[0];
`else
            lane[0] = 1'b0;
`endif
        end else if (src_size[1]) begin
`ifdef DMEM_MISALIGN_CHECK_EN
            misalign = |lane;
`else
            lane = 2'b00;
`endif
        end
    end

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        be = 4'b1111;
        wd = src_wdata;
        case (src_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{src_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << lane;
                wd = {2{src_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = src_wdata;
            end
        endcase
    end

    assign rd_word = mem[src_addr[AW-1:2]];

    always_comb begin
        ld_data = rd_word;
        case (src_size)
            2'b00: ld_data = {{24{~src_unsigned & rd_word[{lane, 3'b111}]}},
                              rd_word[{lane, 3'b000} +: 8]};
            2'b01: ld_data = {{16{~src_unsigned & rd_word[{lane[1], 4'b1111}]}},
                              rd_word[{lane[1], 4'b0000} +: 16]};
            default: ld_data = rd_word;
        endcase
    end

    assign do_write = reset_b && access && src_write && !misalign;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[src_addr[AW-1:2]][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_size     <= 2'b00;
            lat_wdata    <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req_valid) begin
                lat_write    <= req_write;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr[AW-1:0];
                lat_size     <= req_size;
                lat_wdata    <= req_wdata;
            end
            if (access) begin
                rsp_rdata <= (src_write || misalign) ? 32'd0 : ld_data;
                rsp_err   <= misalign;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed self-checking bench for dmem_responder against a byte-array model
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int AWID  = 10;
    localparam int W     = 2;
    localparam int BYTES = 4 * DEPTH;

    logic        clk;
    logic        reset_b;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rm [BYTES];
    logic [31:0] last_rd;
    logic        last_err;

    dmem_responder #(
        .DMEM_DEPTH(DEPTH),
        .DMEM_ADDR_WIDTH(AWID),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array; accesses are plain byte loops.
    task automatic ref_access(input logic w, input logic [31:0] a, input logic [1:0] s,
                              input logic u, input logic [31:0] d,
                              output logic [31:0] rd, output logic er);
        int n;
        int off;
        logic [31:0] v;
        n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        off = int'(a % BYTES);
`ifdef DMEM_MISALIGN_CHECK_EN
        er = (off % n) != 0;
`else
        er  = 1'b0;
        off = off - (off % n);
`endif
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) rm[off + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(rm[off + i]) << (8 * i));
                if (n < 4 && !u && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                rd = v;
            end
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                        input logic [31:0] d, input int hold, input string tag);
        logic [31:0] exp_rd;
        logic        exp_er;
        logic [31:0] rd;
        logic        er;
        int          n;
        int          lat;
        ref_access(w, a, s, u, d, exp_rd, exp_er);
        req_write    = w;
        req_addr     = a;
        req_size     = s;
        req_unsigned = u;
        req_wdata    = d;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(1 + W));
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata, rd);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, 32'(er), 32'(exp_er));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        last_rd  = rd;
        last_err = er;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] exp1, exp2;
        logic        e_dummy;
        logic [15:0] low_half;
        int          lat;

        reset_b      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;
        last_rd      = 32'd0;
        last_err     = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) xact(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, 0, "init");

        xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, "sw 0x10");
        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "lw 0x10");
        chk("lw 0x10 const", last_rd, 32'hDEADBEEF);

        xact(1'b1, 32'h13, 2'd0, 1'b0, 32'h80, 0, "sb 0x13");
        xact(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, "lb 0x13");
        chk("lb 0x13 const", last_rd, 32'hFFFFFF80);
        xact(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, "lbu 0x13");
        chk("lbu 0x13 const", last_rd, 32'h00000080);
        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "lw after sb");
        chk("lw after sb const", last_rd, 32'h80ADBEEF);

        xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, "lw 0x20 pre");
        low_half = last_rd[15:0];
        xact(1'b1, 32'h22, 2'd1, 1'b0, 32'h8001, 0, "sh 0x22");
        xact(1'b0, 32'h22, 2'd1, 1'b1, 32'h0, 0, "lhu 0x22");
        chk("lhu 0x22 const", last_rd, 32'h00008001);
        xact(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 0, "lh 0x22");
        chk("lh 0x22 const", last_rd, 32'hFFFF8001);
        xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, "lw 0x20 post");
        chk("lw 0x20 upper", 32'(last_rd[31:16]), 32'h8001);
        chk("lw 0x20 lower", 32'(last_rd[15:0]), 32'(low_half));

        xact(1'b0, 32'h11, 2'd2, 1'b0, 32'h0, 0, "lw 0x11");
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("lw 0x11 err const", 32'(last_err), 32'd1);
        chk("lw 0x11 rdata const", last_rd, 32'd0);
`else
        chk("lw 0x11 err const", 32'(last_err), 32'd0);
        chk("lw 0x11 rdata const", last_rd, 32'h80ADBEEF);
`endif

        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, "backpressure");

        // Second request held on req_valid throughout; it must only be taken after the handshake.
        ref_access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, exp1, e_dummy);
        ref_access(1'b0, 32'h22, 2'd1, 1'b1, 32'h0, exp2, e_dummy);
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        chk("b2b first accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_addr = 32'h22; req_size = 2'd1; req_unsigned = 1'b1;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b first latency", 32'(lat), 32'(1 + W));
        chk("b2b first rdata", rsp_rdata, exp1);
        chk("b2b resp req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b idle req_ready", 32'(req_ready), 32'd1);
        chk("b2b idle rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b second latency", 32'(lat), 32'(1 + W));
        chk("b2b second rdata", rsp_rdata, exp2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        req_write = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_unsigned = 1'b0;
        req_wdata = 32'h12345678; req_valid = 1'b1;
        chk("rst store accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset_b   = 1'b0;
        @(negedge clk);
        chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst mid req_ready", 32'(req_ready), 32'd1);
        chk("rst mid rsp_rdata", rsp_rdata, 32'd0);
        reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst no response", 32'(rsp_valid), 32'd0);
        end
        xact(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, "lw 0x40 after rst");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[11:8] = 4'h0;
            xact(1'($urandom), a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                 $urandom_range(0, 2), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
